// File: rtl/peak_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : peak_pkg
//  Purpose  : Shared types for the peak serializer: peak record, FSM state
//             encoding, per-record byte count and a byte-select helper.
//             TX_CSUM exists only when PEAK_SERIALIZE_CHECKSUM_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
package peak_pkg;

  localparam int BYTES_PER_PEAK = 7;

  typedef struct packed {
    logic [23:0] freq;
    logic [15:0] phaseA;
    logic [15:0] phaseB;
  } peak_rec;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    TX_SYNC,
    TX_CNT,
    TX_DATA
`ifdef PEAK_SERIALIZE_CHECKSUM_EN
    , TX_CSUM
`endif
  } state_t;

  // Byte 'field' (0..6) of a record in wire order, MSB first per field
  function automatic logic [7:0] peak_byte(input peak_rec r, input logic [2:0] field);
    logic [7:0] b;
    b = 8'h00;
    case (field)
      3'd0:    b = r.freq[23:16];
      3'd1:    b = r.freq[15:8];
      3'd2:    b = r.freq[7:0];
      3'd3:    b = r.phaseA[15:8];
      3'd4:    b = r.phaseA[7:0];
      3'd5:    b = r.phaseB[15:8];
      3'd6:    b = r.phaseB[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/peak_frame_buf.sv
`default_nettype none
// ============================================================================
//  Module   : peak_frame_buf
//  Purpose  : NPEAKS-deep register file of peak records. One synchronous
//             write port, one asynchronous indexed read port. Contents are
//             intentionally not reset.
//  Revision : 1.0 - initial release
// ============================================================================
module peak_frame_buf
  import peak_pkg::*;
#(
  parameter int NPEAKS = 4,
  parameter int IDX_W  = 2
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  peak_rec          wr_data,
  input  logic [IDX_W-1:0] rd_idx,
  output peak_rec          rd_data
);

  peak_rec mem [NPEAKS];

  // Store one incoming record at its arrival slot
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  assign rd_data = mem[rd_idx];

endmodule
`default_nettype wire

// File: rtl/peak_serialize.sv
`default_nettype none
// ============================================================================
//  Module   : peak_serialize
//  Purpose  : Collects a frame of NPEAKS peak records and streams it out as
//             bytes: SYNC, NPEAKS, then 7 bytes per record. With macro
//             PEAK_SERIALIZE_CHECKSUM_EN a trailing checksum byte (negated
//             8-bit sum of all bytes after SYNC) is appended.
//  Revision : 1.0 - initial release
// ============================================================================
module peak_serialize
  import peak_pkg::*;
#(
  parameter int         NPEAKS = 4,
  parameter logic [7:0] SYNC   = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sink_valid,
  input  logic        sink_sop,
  input  logic        sink_eop,
  input  logic [23:0] sink_freq,
  input  logic [15:0] sink_phaseA,
  input  logic [15:0] sink_phaseB,
  input  logic        source_ready,
  output logic        source_valid,
  output logic [7:0]  source_data,
  output logic        source_sop,
  output logic        source_eop,
  output logic        frame_drop
);

  localparam int IDX_W  = (NPEAKS > 1) ? $clog2(NPEAKS) : 1;
  localparam int BCNT_W = $clog2(BYTES_PER_PEAK * NPEAKS + 3);
  // Position of the last record byte in the frame (SYNC is position 0)
  localparam logic [BCNT_W-1:0] LAST_DATA = BCNT_W'(BYTES_PER_PEAK * NPEAKS + 1);
  localparam logic [BCNT_W-1:0] LAST_M1   = BCNT_W'(BYTES_PER_PEAK * NPEAKS);
  localparam logic [8:0]        NPEAKS_C  = 9'(NPEAKS);
  localparam logic [7:0]        NPEAKS_B  = 8'(NPEAKS);

  state_t            state;
  logic [8:0]        rec_cnt;
  logic [IDX_W-1:0]  nxt_rec;
  logic [2:0]        nxt_field;
  logic [BCNT_W-1:0] byte_cnt;
`ifdef PEAK_SERIALIZE_CHECKSUM_EN
  logic [7:0]        csum;
`endif

  peak_rec          wr_data;
  peak_rec          rd_data;
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [7:0]       nxt_byte;
  logic             accept;
  logic             filling;
  logic             in_tx;
  logic             start_tx;
  logic             drop;

  assign filling  = (state == IDLE) || (state == FILL);
  assign in_tx    = !filling;
  assign accept   = source_valid && source_ready;
  assign wr_data  = '{freq: sink_freq, phaseA: sink_phaseA, phaseB: sink_phaseB};
  assign wr_idx   = sink_sop ? '0 : rec_cnt[IDX_W-1:0];
  // A sop always (re)starts at slot 0; continuation records only while room remains
  assign wr_en    = sink_valid &&
                    ((state == IDLE && sink_sop) ||
                     (state == FILL && (sink_sop || rec_cnt < NPEAKS_C)));

  // Frame completes on an eop that brings the count to exactly NPEAKS
  assign start_tx = sink_valid && sink_eop &&
                    ((filling && sink_sop && NPEAKS == 1) ||
                     (state == FILL && !sink_sop && rec_cnt == NPEAKS_C - 9'd1));

  // Discard conditions: sop during transmit, restart/overflow/short frame while filling
  assign drop = sink_valid &&
                ((in_tx && sink_sop) ||
                 (state == FILL && (sink_sop || rec_cnt == NPEAKS_C ||
                                    (sink_eop && rec_cnt != NPEAKS_C - 9'd1))) ||
                 (state == IDLE && sink_sop && sink_eop && NPEAKS != 1));

  assign nxt_byte = peak_byte(rd_data, nxt_field);

  peak_frame_buf #(
    .NPEAKS (NPEAKS),
    .IDX_W  (IDX_W)
  ) u_buf (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_idx  (wr_idx),
    .wr_data (wr_data),
    .rd_idx  (nxt_rec),
    .rd_data (rd_data)
  );

  // Frame collection / byte transmission FSM with registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      rec_cnt      <= '0;
      nxt_rec      <= '0;
      nxt_field    <= '0;
      byte_cnt     <= '0;
      source_valid <= 1'b0;
      source_data  <= 8'h00;
      source_sop   <= 1'b0;
      source_eop   <= 1'b0;
      frame_drop   <= 1'b0;
`ifdef PEAK_SERIALIZE_CHECKSUM_EN
      csum         <= 8'h00;
`endif
    end else begin
      frame_drop <= drop;
      case (state)
        IDLE, FILL: begin
          if (start_tx) begin
            state        <= TX_SYNC;
            rec_cnt      <= '0;
            nxt_rec      <= '0;
            nxt_field    <= '0;
            byte_cnt     <= '0;
            source_valid <= 1'b1;
            source_data  <= SYNC;
            source_sop   <= 1'b1;
            source_eop   <= 1'b0;
          end else if (sink_valid && sink_sop) begin
            state   <= sink_eop ? IDLE : FILL;
            rec_cnt <= sink_eop ? 9'd0 : 9'd1;
          end else if (sink_valid && state == FILL) begin
            if (drop) begin
              state   <= IDLE;
              rec_cnt <= '0;
            end else begin
              rec_cnt <= rec_cnt + 9'd1;
            end
          end
        end

        TX_SYNC: begin
          if (accept) begin
            state       <= TX_CNT;
            byte_cnt    <= byte_cnt + BCNT_W'(1);
            source_data <= NPEAKS_B;
            source_sop  <= 1'b0;
`ifdef PEAK_SERIALIZE_CHECKSUM_EN
            csum        <= NPEAKS_B;
`endif
          end
        end

        TX_CNT, TX_DATA: begin
          if (accept) begin
            byte_cnt <= byte_cnt + BCNT_W'(1);
            if (state == TX_DATA && byte_cnt == LAST_DATA) begin
`ifdef PEAK_SERIALIZE_CHECKSUM_EN
              state       <= TX_CSUM;
              source_data <= -csum;
              source_eop  <= 1'b1;
`else
              state        <= IDLE;
              source_valid <= 1'b0;
              source_data  <= 8'h00;
              source_eop   <= 1'b0;
`endif
            end else begin
              state       <= TX_DATA;
              source_data <= nxt_byte;
`ifdef PEAK_SERIALIZE_CHECKSUM_EN
              csum        <= csum + nxt_byte;
`else
              source_eop  <= (byte_cnt == LAST_M1);
`endif
              if (nxt_field == 3'd6) begin
                nxt_field <= 3'd0;
                nxt_rec   <= nxt_rec + IDX_W'(1);
              end else begin
                nxt_field <= nxt_field + 3'd1;
              end
            end
          end
        end

`ifdef PEAK_SERIALIZE_CHECKSUM_EN
        TX_CSUM: begin
          if (accept) begin
            state        <= IDLE;
            source_valid <= 1'b0;
            source_data  <= 8'h00;
            source_eop   <= 1'b0;
          end
        end
`endif

        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_peak_serialize.sv
`default_nettype none
// ============================================================================
//  Module   : tb_peak_serialize
//  Purpose  : Directed self-checking bench for peak_serialize with NPEAKS=2.
//             Checksum expectations follow PEAK_SERIALIZE_CHECKSUM_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_peak_serialize;

  localparam int NP = 2;
`ifdef PEAK_SERIALIZE_CHECKSUM_EN
  localparam int NEXP = 17;
`else
  localparam int NEXP = 16;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        sink_valid, sink_sop, sink_eop;
  logic [23:0] sink_freq;
  logic [15:0] sink_phaseA, sink_phaseB;
  logic        source_ready;
  logic        source_valid;
  logic [7:0]  source_data;
  logic        source_sop, source_eop, frame_drop;

  logic [7:0] exp_bytes [17] = '{8'hA5, 8'h02, 8'h00, 8'h12, 8'h34, 8'h40, 8'h00, 8'hC0, 8'h00,
                                 8'h00, 8'h01, 8'h00, 8'h00, 8'h01, 8'hFF, 8'hFF, 8'hB8};

  int n_checks = 0;
  int n_fail   = 0;
  int drop_cnt = 0;
  logic [9:0] mon_q [$];

  peak_serialize #(.NPEAKS(NP), .SYNC(8'hA5)) dut (
    .clk          (clk),
    .reset        (reset),
    .sink_valid   (sink_valid),
    .sink_sop     (sink_sop),
    .sink_eop     (sink_eop),
    .sink_freq    (sink_freq),
    .sink_phaseA  (sink_phaseA),
    .sink_phaseB  (sink_phaseB),
    .source_ready (source_ready),
    .source_valid (source_valid),
    .source_data  (source_data),
    .source_sop   (source_sop),
    .source_eop   (source_eop),
    .frame_drop   (frame_drop)
  );

  always #5 clk = ~clk;

  // Capture accepted bytes and drop pulses mid-cycle
  always @(negedge clk) begin
    if (!reset && source_valid && source_ready)
      mon_q.push_back({source_sop, source_eop, source_data});
    if (frame_drop) drop_cnt++;
  end

  task automatic drive_rec(input logic s, input logic e, input logic [23:0] f,
                           input logic [15:0] a, input logic [15:0] b);
    @(posedge clk); #1;
    sink_valid = 1'b1; sink_sop = s; sink_eop = e;
    sink_freq = f; sink_phaseA = a; sink_phaseB = b;
  endtask

  task automatic sink_idle();
    @(posedge clk); #1;
    sink_valid = 1'b0; sink_sop = 1'b0; sink_eop = 1'b0;
  endtask

  task automatic send_frame_a();
    drive_rec(1'b1, 1'b0, 24'h001234, 16'h4000, 16'hC000);
    drive_rec(1'b0, 1'b1, 24'h000100, 16'h0001, 16'hFFFF);
  endtask

  task automatic wait_bytes(input int n, output bit ok);
    for (int i = 0; i < 300; i++) begin
      if (mon_q.size() >= n) break;
      @(posedge clk); #1;
    end
    ok = (mon_q.size() >= n);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (source_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", source_valid); end
    n_checks++; if (source_data !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h exp 00", source_data); end
    n_checks++; if (source_sop !== 1'b0) begin n_fail++; $display("FAIL reset_sop got %b exp 0", source_sop); end
    n_checks++; if (source_eop !== 1'b0) begin n_fail++; $display("FAIL reset_eop got %b exp 0", source_eop); end
    n_checks++; if (frame_drop !== 1'b0) begin n_fail++; $display("FAIL reset_drop got %b exp 0", frame_drop); end
    reset = 1'b0;
  endtask

  task automatic test_idle_noise();
    drop_cnt = 0; mon_q.delete();
    drive_rec(1'b0, 1'b0, 24'h111111, 16'h2222, 16'h3333);
    drive_rec(1'b0, 1'b1, 24'h444444, 16'h5555, 16'h6666);
    sink_idle();
    repeat (10) @(posedge clk);
    #1;
    n_checks++; if (drop_cnt !== 0) begin n_fail++; $display("FAIL idle_drop got %0d exp 0", drop_cnt); end
    n_checks++; if (mon_q.size() !== 0) begin n_fail++; $display("FAIL idle_output got %0d bytes exp 0", mon_q.size()); end
  endtask

  task automatic test_basic();
    logic [9:0] e;
    mon_q.delete(); source_ready = 1'b1;
    send_frame_a();
    n_checks++; if (source_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid got %b exp 0", source_valid); end
    sink_idle();
    n_checks++; if ({source_valid, source_sop, source_data} !== {1'b1, 1'b1, 8'hA5})
      begin n_fail++; $display("FAIL basic_latency got v=%b sop=%b d=%h exp v=1 sop=1 d=a5", source_valid, source_sop, source_data); end
    repeat (NEXP) @(posedge clk);
    #1;
    n_checks++; if (mon_q.size() !== NEXP) begin n_fail++; $display("FAIL basic_no_bubble got %0d bytes exp %0d", mon_q.size(), NEXP); end
    n_checks++; if ({source_valid, source_data} !== 9'h000) begin n_fail++; $display("FAIL basic_valid_fall got v=%b d=%h exp v=0 d=00", source_valid, source_data); end
    for (int i = 0; i < NEXP; i++) begin
      e = {1'(i == 0), 1'(i == NEXP - 1), exp_bytes[i]};
      n_checks++;
      if (i >= mon_q.size() || mon_q[i] !== e) begin
        n_fail++; $display("FAIL basic_byte%0d got %h exp %h", i, (i < mon_q.size()) ? mon_q[i] : 10'h3FF, e);
      end
    end
  endtask

  task automatic test_stall();
    logic [3:0]  pat = 4'b1001;
    logic [10:0] cur, prev;
    logic        prev_rdy;
    logic [9:0]  e;
    int          k, stalls;
    mon_q.delete(); source_ready = 1'b1;
    send_frame_a();
    sink_idle();
    prev = '0; prev_rdy = 1'b1; k = 0; stalls = 0;
    for (int c = 0; c < 300; c++) begin
      cur = {source_valid, source_sop, source_eop, source_data};
      if (prev[10] && !prev_rdy) begin
        stalls++;
        n_checks++;
        if (cur !== prev) begin n_fail++; $display("FAIL stall_hold got %h exp %h", cur, prev); end
      end
      if (mon_q.size() >= NEXP && !source_valid) break;
      source_ready = pat[k % 4];
      prev = cur; prev_rdy = source_ready; k++;
      @(posedge clk); #1;
    end
    source_ready = 1'b1;
    n_checks++; if (stalls == 0) begin n_fail++; $display("FAIL stall_seen got 0 stalls exp >0"); end
    n_checks++; if (mon_q.size() !== NEXP) begin n_fail++; $display("FAIL stall_count got %0d exp %0d", mon_q.size(), NEXP); end
    for (int i = 0; i < NEXP; i++) begin
      e = {1'(i == 0), 1'(i == NEXP - 1), exp_bytes[i]};
      n_checks++;
      if (i >= mon_q.size() || mon_q[i] !== e) begin
        n_fail++; $display("FAIL stall_byte%0d got %h exp %h", i, (i < mon_q.size()) ? mon_q[i] : 10'h3FF, e);
      end
    end
  endtask

  task automatic test_sop_during_tx();
    bit ok;
    logic [9:0] e;
    drop_cnt = 0; mon_q.delete(); source_ready = 1'b1;
    send_frame_a();
    sink_idle();
    wait_bytes(5, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL sop_tx_timeout got %0d bytes exp 5", mon_q.size()); end
    drive_rec(1'b1, 1'b0, 24'hABCDEF, 16'h1357, 16'h2468);
    drive_rec(1'b0, 1'b1, 24'hFEDCBA, 16'h7531, 16'h8642);
    sink_idle();
    wait_bytes(NEXP, ok);
    repeat (30) @(posedge clk);
    #1;
    n_checks++; if (drop_cnt !== 1) begin n_fail++; $display("FAIL sop_tx_drop got %0d pulses exp 1", drop_cnt); end
    n_checks++; if (mon_q.size() !== NEXP) begin n_fail++; $display("FAIL sop_tx_count got %0d exp %0d", mon_q.size(), NEXP); end
    for (int i = 0; i < NEXP; i++) begin
      e = {1'(i == 0), 1'(i == NEXP - 1), exp_bytes[i]};
      n_checks++;
      if (i >= mon_q.size() || mon_q[i] !== e) begin
        n_fail++; $display("FAIL sop_tx_byte%0d got %h exp %h", i, (i < mon_q.size()) ? mon_q[i] : 10'h3FF, e);
      end
    end
  endtask

  task automatic test_short_frame();
    bit ok;
    logic [9:0] e;
    drop_cnt = 0; mon_q.delete(); source_ready = 1'b1;
    drive_rec(1'b1, 1'b1, 24'h0A0B0C, 16'h0D0E, 16'h0F10);
    sink_idle();
    repeat (4) @(posedge clk);
    #1;
    n_checks++; if (drop_cnt !== 1) begin n_fail++; $display("FAIL short_drop got %0d exp 1", drop_cnt); end
    drive_rec(1'b1, 1'b0, 24'h000001, 16'h0002, 16'h0003);
    drive_rec(1'b0, 1'b0, 24'h000004, 16'h0005, 16'h0006);
    drive_rec(1'b0, 1'b1, 24'h000007, 16'h0008, 16'h0009);
    sink_idle();
    repeat (4) @(posedge clk);
    #1;
    n_checks++; if (drop_cnt !== 2) begin n_fail++; $display("FAIL long_drop got %0d exp 2", drop_cnt); end
    n_checks++; if (mon_q.size() !== 0) begin n_fail++; $display("FAIL bad_frame_output got %0d bytes exp 0", mon_q.size()); end
    send_frame_a();
    sink_idle();
    wait_bytes(NEXP, ok);
    repeat (5) @(posedge clk);
    #1;
    n_checks++; if (drop_cnt !== 2) begin n_fail++; $display("FAIL recover_drop got %0d exp 2", drop_cnt); end
    for (int i = 0; i < NEXP; i++) begin
      e = {1'(i == 0), 1'(i == NEXP - 1), exp_bytes[i]};
      n_checks++;
      if (i >= mon_q.size() || mon_q[i] !== e) begin
        n_fail++; $display("FAIL recover_byte%0d got %h exp %h", i, (i < mon_q.size()) ? mon_q[i] : 10'h3FF, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int sz;
    logic [9:0] e;
    mon_q.delete(); source_ready = 1'b1;
    send_frame_a();
    sink_idle();
    wait_bytes(4, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL rst_mid_timeout got %0d bytes exp 4", mon_q.size()); end
    reset = 1'b1;
    @(posedge clk); #1;
    n_checks++; if ({source_valid, source_sop, source_eop, source_data} !== 11'h000)
      begin n_fail++; $display("FAIL rst_mid_outputs got v=%b s=%b e=%b d=%h exp all 0", source_valid, source_sop, source_eop, source_data); end
    sz = mon_q.size();
    reset = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    n_checks++; if (mon_q.size() !== sz || source_valid !== 1'b0)
      begin n_fail++; $display("FAIL rst_mid_resume got %0d bytes v=%b exp %0d bytes v=0", mon_q.size(), source_valid, sz); end
    mon_q.delete();
    send_frame_a();
    sink_idle();
    wait_bytes(NEXP, ok);
    for (int i = 0; i < NEXP; i++) begin
      e = {1'(i == 0), 1'(i == NEXP - 1), exp_bytes[i]};
      n_checks++;
      if (i >= mon_q.size() || mon_q[i] !== e) begin
        n_fail++; $display("FAIL rst_next_byte%0d got %h exp %h", i, (i < mon_q.size()) ? mon_q[i] : 10'h3FF, e);
      end
    end
  endtask

  initial begin
    reset = 1'b1; sink_valid = 1'b0; sink_sop = 1'b0; sink_eop = 1'b0;
    sink_freq = '0; sink_phaseA = '0; sink_phaseB = '0; source_ready = 1'b1;
    test_reset();
    test_idle_noise();
    test_basic();
    test_stall();
    test_sop_during_tx();
    test_short_frame();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
